pixel_stream_packer: RTL and testbench
======================================

// Module: pixel_stream_packer
// PURPOSE
//   Output-side sink for image_processor: accepts one processed pixel per handshake (gray byte + binary bit),
//   tracks raster position and packs pixels into a byte stream with frame/line markers for a downstream writer.
//   Gray mode emits one byte per pixel; binary mode packs 8 pixels per byte. A small FIFO absorbs backpressure.
// PARAMETERS
//   FRAME_WIDTH   128  pixels per line; must be a multiple of 8
//   FRAME_HEIGHT  128  lines per frame
//   FIFO_DEPTH    4    output FIFO entries; power of two, >= 2
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   rst_n        in   1   synchronous reset, active low
//   mode         in   1   0 = gray bytes, 1 = packed binary; sampled only on the first pixel of a frame
//   in_valid     in   1   pixel present on in_gray/in_bin
//   in_ready     out  1   packer can accept a pixel this cycle
//   in_gray      in   8   gray pixel value
//   in_bin       in   1   binary pixel value
//   out_valid    out  1   byte present on out_data/flags
//   out_ready    in   1   downstream accepts byte
//   out_data     out  8   packed byte
//   out_sof      out  1   byte contains pixel (0,0)
//   out_eol      out  1   byte contains last pixel of a line
//   out_eof      out  1   byte contains last pixel of the frame
//   frame_count  out  16  completed frames (last pixel accepted)
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): x=0, y=0, shift reg=0, bit index=0, FIFO emptied, latched mode=0,
//   frame_count=0, out_valid=0, out_data=0, out_sof/eol/eof=0. in_ready=0 while rst_n=0, else in_ready=!fifo_full.
// - Reset mid-frame/mid-byte: partial byte, queued bytes and position discarded; next accepted pixel is (0,0).
// - Accept = in_valid & in_ready. No state changes on cycles without acceptance.
// - Position: x counts 0..FRAME_WIDTH-1; at x=W-1, x->0 and y++; at (W-1,H-1), y->0 and frame_count++
//   (16-bit wrap 65535->0).
// - Mode: on acceptance with x=0,y=0, mode_q <= mode and that pixel already uses the new mode;
//   mode changes at any other time are ignored until the next frame start.
// - Gray mode: each accepted pixel pushes {data=in_gray, sof=(x==0&&y==0), eol=(x==W-1), eof=(x==W-1&&y==H-1)}.
// - Binary mode: in_bin is written to bit (x mod 8) of the shift reg, so the leftmost pixel lands in the LSB.
//   On acceptance with x mod 8 = 7, the completed byte (including the current bit) is pushed.
//   sof is set if the byte holds x=0,y=0; eol/eof come from the pixel that completes the byte.
//   Shift reg clears after each push.
// - Push is registered: the entry is visible at the FIFO head on the cycle after acceptance.
//   Latency is 1 cycle from the completing pixel to out_valid when the FIFO was empty.
// - out_valid = !fifo_empty; out_data/flags show the FIFO head and are stable while out_valid & !out_ready.
//   Pop = out_valid & out_ready.
// - Full: in_ready=0 even if a pop occurs the same cycle (no combinational ready from out_ready).
//   Binary-mode pixels that do not complete a byte still require in_ready=1.
// - Simultaneous push and pop with FIFO neither full nor empty: count unchanged, ordering preserved.
// - Push into an empty FIFO with a pop the same cycle cannot happen; out_valid is 0 that cycle.
// - FIFO occupancy never exceeds FIFO_DEPTH; no byte is ever dropped or duplicated.
// TESTING
// 1. W=8,H=2, gray, out_ready=1, pixels 0..15 back-to-back.
//    -> bytes 0..15; sof on byte 0; eol on bytes 7,15; eof on byte 15; frame_count=1; first out_valid 1 cycle after first accept.
// 2. W=8,H=2, binary, in_bin pattern 1,0,0,0,0,0,0,1 then 8 ones.
//    -> two bytes 0x81 (sof,eol) and 0xFF (eol,eof); frame_count=1.
// 3. FIFO_DEPTH=4, gray, out_ready=0, 6 valid pixels.
//    -> in_ready drops after 4 accepts; raising out_ready drains 4 bytes in order, then the remaining 2 are accepted.
//    -> data held stable throughout the stall.
// 4. mode toggled 0->1 at pixel 5 of frame 0.
//    -> frame 0 stays gray (16 bytes); mode held 1 at frame 1 start -> frame 1 emits 2 packed bytes with sof on the first.
// 5. rst_n low for 1 cycle after 3 binary pixels and 2 queued gray bytes.
//    -> out_valid=0, frame_count=0, in_ready=0 during reset; next pixel produces sof; no stale bits in the next byte.
// 6. Random in_valid/out_ready over 3 frames of 128x128 (binary).
//    -> exactly 3*2048 bytes; eof count=3; byte contents match a reference model.

Source files
------------

// File: rtl/pixel_stream_packer_if.sv
// pixel_stream_packer_if: pixel input and packed-byte output handshakes of the packer
interface pixel_stream_packer_if;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_gray;
  logic       in_bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  modport master (
    output mode, in_valid, in_gray, in_bin, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );
  modport slave (
    input  mode, in_valid, in_gray, in_bin, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: tracks raster position and packs gray/binary pixels into a flagged byte stream behind a FIFO
module pixel_stream_packer #(
  parameter int FRAME_WIDTH  = 128,
  parameter int FRAME_HEIGHT = 128,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_stream_packer_if.slave bus,
  output logic [15:0]          frame_count
);
  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = FRAME_HEIGHT > 1 ? $clog2(FRAME_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    sr;
  logic          mode_q;
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, empty, acc, first, cur_mode, last_x, last_y, push, pop;
  logic [7:0]    byte_d;
  logic [10:0]   entry;
  always_comb begin
    full          = cnt == (AW+1)'(FIFO_DEPTH);
    empty         = cnt == '0;
    bus.in_ready  = rst_n & !full;
    acc           = bus.in_valid & bus.in_ready;
    first         = x == '0 && y == '0;
    cur_mode      = first ? bus.mode : mode_q;
    last_x        = x == XW'(FRAME_WIDTH - 1);
    last_y        = y == YW'(FRAME_HEIGHT - 1);
    byte_d        = cur_mode ? sr | (8'(bus.in_bin) << x[2:0]) : bus.in_gray;
    entry         = {y == '0 && (cur_mode ? 32'(x) < 8 : x == '0), last_x, last_x & last_y, byte_d};
    push          = acc & (!cur_mode | x[2:0] == 3'd7);
    pop           = !empty & bus.out_ready;
    bus.out_valid = !empty;
    {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_data} = empty ? 11'd0 : mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      sr          <= '0;
      mode_q      <= 1'b0;
      frame_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
    end else begin
      if (acc) begin
        x <= last_x ? '0 : x + 1'b1;
        if (last_x) y <= last_y ? '0 : y + 1'b1;
        if (last_x & last_y) frame_count <= frame_count + 16'd1;
        if (first) mode_q <= bus.mode;
        if (cur_mode) sr <= push ? 8'd0 : byte_d;
      end
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb_pixel_stream_packer: vector table, corner sequences and randomized frames against a byte-level reference
module tb_pixel_stream_packer;
  typedef struct {
    logic        mode;
    logic [7:0]  gray;
    logic        bin;
    logic        push;
    logic [10:0] want;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_rst_n = 1'b0;
  logic [15:0] s_fc, b_fc;
  int          checks = 0;
  int          errors = 0;
  logic [10:0] sq [$];
  logic [7:0]  bexp [6144];
  int          bj = 0;
  int          b_bad = 0;
  int          b_eof = 0;
  vec_t        tbl [32];
  pixel_stream_packer_if s ();
  pixel_stream_packer_if b ();
  pixel_stream_packer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(2), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(s.slave), .frame_count(s_fc)
  );
  pixel_stream_packer #(.FRAME_WIDTH(128), .FRAME_HEIGHT(128), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .bus(b.slave), .frame_count(b_fc)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (s.out_valid && s.out_ready) sq.push_back({s.out_sof, s.out_eol, s.out_eof, s.out_data});
  // Expected byte j of the random run: frame-relative index gives the flags, bexp gives the data
  always @(negedge clk)
    if (b.out_valid && b.out_ready) begin
      int idx;
      idx = bj % 2048;
      if (bj >= 6144 || {b.out_sof, b.out_eol, b.out_eof, b.out_data} !== {idx == 0, idx % 16 == 15, idx == 2047, bexp[bj]})
        b_bad++;
      if (b.out_eof) b_eof++;
      bj++;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic m, input logic [7:0] g, input logic bb);
    int n;
    n = 0;
    s.mode = m;
    s.in_gray = g;
    s.in_bin = bb;
    s.in_valid = 1'b1;
    @(negedge clk);
    while (!s.in_ready && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!s.in_ready) chk("feed_timeout", 32'(s.in_ready), 1);
    tick();
    s.in_valid = 1'b0;
  endtask
  task automatic wait_bytes(input int k);
    for (int n = 0; n < 60 && sq.size() < k; n++) tick();
  endtask
  initial begin
    int p, cyc;
    logic [15:0] pb;
    {s.mode, s.in_valid, s.in_gray, s.in_bin, s.out_ready} = '0;
    {b.mode, b.in_valid, b.in_gray, b.in_bin, b.out_ready} = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(s.in_ready), 0);
    chk("rst_out_valid", 32'(s.out_valid), 0);
    chk("rst_out_bus", {s.out_sof, s.out_eol, s.out_eof, s.out_data}, 0);
    chk("rst_frame_count", s_fc, 0);
    tick();
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    // Frame 0 gray with mode raised at pixel 5, frame 1 binary
    pb = 16'hFF81;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{mode: i >= 5, gray: 8'(i), bin: 1'b0, push: 1'b1, want: {i == 0, i % 8 == 7, i == 15, 8'(i)}};
    for (int j = 0; j < 16; j++)
      tbl[16+j] = '{mode: 1'b1, gray: 8'hEE, bin: pb[j], push: j % 8 == 7,
                    want: j == 7 ? {3'b110, 8'h81} : j == 15 ? {3'b011, 8'hFF} : 11'd0};
    s.out_ready = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) begin
        s.mode = tbl[i].mode;
        s.in_gray = tbl[i].gray;
        s.in_bin = tbl[i].bin;
        s.in_valid = 1'b1;
      end else s.in_valid = 1'b0;
      @(negedge clk);
      if (i < 32) chk($sformatf("v%0d_in_ready", i), 32'(s.in_ready), 1);
      if (i > 0) begin
        chk($sformatf("v%0d_out_valid", i - 1), 32'(s.out_valid), 32'(tbl[i-1].push));
        if (tbl[i-1].push)
          chk($sformatf("v%0d_out", i - 1), {s.out_sof, s.out_eol, s.out_eof, s.out_data}, tbl[i-1].want);
      end else chk("v_pre_out_valid", 32'(s.out_valid), 0);
      if (i == 16) chk("t1_frame_count", s_fc, 1);
      tick();
    end
    chk("t2_frame_count", s_fc, 2);
    // Backpressure: four bytes fill the FIFO, data must hold through the stall
    sq.delete();
    s.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) feed(1'b0, 8'(8'hA0 + k), 1'b0);
    s.in_gray = 8'hA4;
    s.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_full_in_ready", 32'(s.in_ready), 0);
      chk("t3_hold_valid", 32'(s.out_valid), 1);
      chk("t3_hold_data", s.out_data, 8'hA0);
      tick();
    end
    s.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_full_ready_with_pop", 32'(s.in_ready), 0);
    tick();
    feed(1'b0, 8'hA4, 1'b0);
    feed(1'b0, 8'hA5, 1'b0);
    wait_bytes(6);
    chk("t3_count", sq.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < sq.size()) chk($sformatf("t3_byte%0d", k), sq[k], {k == 0, 2'b00, 8'(8'hA0 + k)});
    // Finish frame 2 with two bytes queued, start frame 3 binary, then reset mid-byte
    for (int k = 6; k < 14; k++) feed(1'b0, 8'(k), 1'b0);
    s.out_ready = 1'b0;
    feed(1'b0, 8'd14, 1'b0);
    feed(1'b0, 8'd15, 1'b0);
    for (int k = 0; k < 3; k++) feed(1'b1, 8'h00, 1'b1);
    @(negedge clk);
    chk("t5_fc_before", s_fc, 3);
    chk("t5_queued_valid", 32'(s.out_valid), 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_in_ready", 32'(s.in_ready), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", 32'(s.out_valid), 0);
    chk("t5_frame_count", s_fc, 0);
    chk("t5_out_bus", {s.out_sof, s.out_eol, s.out_eof, s.out_data}, 0);
    tick();
    sq.delete();
    s.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) feed(1'b1, 8'h00, k == 7);
    wait_bytes(1);
    repeat (3) tick();
    chk("t5_count", sq.size(), 1);
    if (sq.size() > 0) chk("t5_byte", sq[0], {3'b110, 8'h80});
    // Three random 128x128 binary frames
    for (int i = 0; i < 6144; i++) bexp[i] = 8'($urandom);
    b.mode = 1'b1;
    p = 0;
    cyc = 0;
    while ((p < 49152 || bj < 6144) && cyc < 70000) begin
      b.in_valid = p < 49152 && $urandom_range(31) != 0;
      if (p < 49152) b.in_bin = bexp[p / 8][p % 8];
      b.out_ready = $urandom_range(3) == 0;
      @(negedge clk);
      if (b.in_valid && b.in_ready) p++;
      tick();
      cyc++;
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    repeat (10) tick();
    chk("t6_pixels", p, 49152);
    chk("t6_bytes", bj, 6144);
    chk("t6_eof", b_eof, 3);
    chk("t6_bad_bytes", b_bad, 0);
    chk("t6_frame_count", b_fc, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
